// File: rtl/mul_operand_sequencer.sv
// Operand FIFO feeding an external multiplier one pair at a time, returning tagged products.
// Optional BUSY watchdog with a sticky err output is built when MUL_SEQ_TIMEOUT_EN is defined.
module mul_operand_sequencer #(
    parameter int WIDTH   = 128,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_enable,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_ab,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2*WIDTH-1:0]       res_data,
    output logic [TAG_W-1:0]         res_tag,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef MUL_SEQ_TIMEOUT_EN
    ,
    output logic                     err
`endif
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("mul_operand_sequencer: DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("mul_operand_sequencer: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } state_e;

    logic [WIDTH-1:0]   mem_a [DEPTH];
    logic [WIDTH-1:0]   mem_b [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               ready_q, ready_d;
    logic               push, pop;

    state_e             state_q, state_d;
    logic               en_q, en_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               res_valid_q, res_valid_d;
    logic [2*WIDTH-1:0] res_data_q, res_data_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic [TAG_W-1:0]   seq_q, seq_d;

`ifdef MUL_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
`endif

    assign push = in_valid && ready_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        ready_d  = (count_d != (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q] <= in_a;
            mem_b[wr_ptr_q] <= in_b;
        end
    end

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        seq_d       = seq_q;
        rd_ptr_d    = rd_ptr_q;
        pop         = 1'b0;
`ifdef MUL_SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (count_q != '0 && !res_valid_q) begin
                    pop      = 1'b1;
                    opa_d    = mem_a[rd_ptr_q];
                    opb_d    = mem_b[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    state_d  = BUSY;
`ifdef MUL_SEQ_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                end
            end
            BUSY: begin
                // done only counts once enable has actually been presented to the multiplier
                if (en_q && mul_done) begin
                    res_data_d  = mul_ab;
                    res_tag_d   = seq_q;
                    seq_d       = seq_q + TAG_W'(1);
                    res_valid_d = 1'b1;
                    en_d        = 1'b0;
                    state_d     = GAP;
                end
`ifdef MUL_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    en_d    = 1'b0;
                    state_d = GAP;
                end else begin
                    en_d  = 1'b1;
                    tmo_d = tmo_q + TMO_W'(1);
                end
`else
                else begin
                    en_d = 1'b1;
                end
`endif
            end
            GAP: begin
                en_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                en_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            state_q     <= IDLE;
            en_q        <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            seq_q       <= '0;
`ifdef MUL_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            state_q     <= state_d;
            en_q        <= en_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
            seq_q       <= seq_d;
`ifdef MUL_SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready   = ready_q;
    assign mul_a      = opa_q;
    assign mul_b      = opb_q;
    assign mul_enable = en_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_tag    = res_tag_q;
    assign fifo_level = count_q;
`ifdef MUL_SEQ_TIMEOUT_EN
    assign err        = err_q;
`endif

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Randomized self-checking bench for mul_operand_sequencer with a queue-based reference model
// and a behavioural multiplier responder; the watchdog scenario builds with MUL_SEQ_TIMEOUT_EN.
module tb_mul_operand_sequencer;

    localparam int W  = 64;
    localparam int D  = 4;
    localparam int TW = 4;
    localparam int PW = 2 * W;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a, in_b;
    logic [W-1:0]      mul_a, mul_b;
    logic              mul_enable;
    logic              mul_done;
    logic [PW-1:0]     mul_ab;
    logic              res_valid;
    logic              res_ready;
    logic [PW-1:0]     res_data;
    logic [TW-1:0]     res_tag;
    logic [$clog2(D):0] fifo_level;
`ifdef MUL_SEQ_TIMEOUT_EN
    logic              err;
`endif

    mul_operand_sequencer #(
        .WIDTH   (W),
        .DEPTH   (D),
        .TAG_W   (TW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_enable (mul_enable),
        .mul_done   (mul_done),
        .mul_ab     (mul_ab),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .fifo_level (fifo_level)
`ifdef MUL_SEQ_TIMEOUT_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: accepted pairs in order, next expected tag, observed results
    logic [2*W-1:0]   exp_q[$];
    logic [TW-1:0]    exp_tag;
    logic [TW+PW-1:0] got_q[$];

    int unsigned mul_lat = 4;
    bit          stall = 1'b0;
    bit          rand_ready = 1'b0;
    bit          ready_force = 1'b0;
    int unsigned gap_viol = 0;
    int unsigned hold_viol = 0;

    function automatic logic [PW-1:0] model_prod(input logic [2*W-1:0] pr);
        logic [PW-1:0] a, b;
        a = {{W{1'b0}}, pr[2*W-1:W]};
        b = {{W{1'b0}}, pr[W-1:0]};
        return a * b;
    endfunction

    // behavioural multiplier: asserts done for one cycle mul_lat cycles after enable rises
    initial begin
        int unsigned lat;
        logic [PW-1:0] xa, xb;
        lat = 0;
        mul_done = 1'b0;
        mul_ab = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || mul_done) begin
                mul_done = 1'b0;
                lat = 0;
            end else if (mul_enable && !stall) begin
                lat++;
                if (lat >= mul_lat) begin
                    xa = {{W{1'b0}}, mul_a};
                    xb = {{W{1'b0}}, mul_b};
                    mul_ab = xa * xb;
                    mul_done = 1'b1;
                end
            end else begin
                lat = 0;
            end
        end
    end

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // result collector and multiplier-interface protocol watch
    logic          prev_done_hs = 1'b0;
    logic          prev_en = 1'b0;
    logic [W-1:0]  prev_a = '0, prev_b = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && res_ready) got_q.push_back({res_tag, res_data});
            if (prev_done_hs && mul_enable) gap_viol++;
            if (prev_en && mul_enable && (mul_a !== prev_a || mul_b !== prev_b)) hold_viol++;
            prev_done_hs = mul_done && mul_enable;
            prev_en = mul_enable;
            prev_a = mul_a;
            prev_b = mul_b;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        ready_force = 1'b1;
        rand_ready = 1'b0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        tick();
        exp_q.delete();
        got_q.delete();
        exp_tag = '0;
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int unsigned budget, input bit must, output bit acc);
        int unsigned waited;
        waited = 0;
        acc = 1'b0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!acc && waited < budget) begin
            @(negedge clk); acc = in_ready;
            tick();
            waited++;
        end
        in_valid = 1'b0;
        if (acc) exp_q.push_back({a, b});
        else if (must) begin
            n_cmp++; n_bad++;
            $display("FAIL push_accept: got in_ready=0 for %0d cycles want acceptance", budget);
        end
    endtask

    task automatic wait_results(input int n, input int unsigned budget, output bit ok);
        int unsigned c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready, mul_enable, mul_a, mul_b, res_valid, res_data, res_tag, fifo_level} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b en=%b a=%h b=%h v=%b d=%h tag=%h lvl=%0d want all zero",
                     in_ready, mul_enable, mul_a, mul_b, res_valid, res_data, res_tag, fifo_level);
        end
`ifdef MUL_SEQ_TIMEOUT_EN
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
`endif
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_edge: got %b want 0", in_ready); end
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_edge: got %b want 1", in_ready); end
        exp_q.delete();
        got_q.delete();
        exp_tag = '0;
    endtask

    task automatic test_basic();
        bit acc, ok;
        logic [TW+PW-1:0] have;
        ready_force = 1'b1;
        mul_lat = 10;
        push_pair(W'(3), W'(5), 200, 1'b1, acc);
        n_cmp++;
        if (mul_enable !== 1'b0) begin n_bad++; $display("FAIL en_at_push_edge: got %b want 0", mul_enable); end
        tick();
        n_cmp++;
        if ({mul_enable, fifo_level} !== {1'b0, 3'd0}) begin
            n_bad++; $display("FAIL en_at_edge_t1: got en=%b lvl=%0d want en=0 lvl=0", mul_enable, fifo_level);
        end
        tick();
        n_cmp++;
        if ({mul_enable, mul_a, mul_b} !== {1'b1, W'(3), W'(5)}) begin
            n_bad++; $display("FAIL en_at_edge_t2: got en=%b a=%0d b=%0d want en=1 a=3 b=5", mul_enable, mul_a, mul_b);
        end
        wait_results(1, 100, ok);
        n_cmp++;
        have = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        if (!ok || have !== {TW'(0), PW'(15)}) begin
            n_bad++; $display("FAIL basic_result: got %h want tag 0 data 15", have);
        end
        void'(exp_q.pop_front());
        exp_tag++;
    endtask

    task automatic test_fill();
        bit acc, ok;
        logic [TW+PW-1:0] have, want;
        logic [2*W-1:0] pr;
        int unsigned c;
        do_reset();
        ready_force = 1'b0;
        mul_lat = 3;
        for (int i = 0; i < 5; i++) push_pair(W'($urandom), W'($urandom), 1, 1'b1, acc);
        push_pair(W'($urandom), W'($urandom), 4, 1'b0, acc);
        n_cmp++;
        if ({acc, in_ready, fifo_level} !== {1'b0, 1'b0, 3'd4}) begin
            n_bad++; $display("FAIL fill_full: got acc6=%b rdy=%b lvl=%0d want acc6=0 rdy=0 lvl=4", acc, in_ready, fifo_level);
        end
        c = 0;
        while (res_valid !== 1'b1 && c < 50) begin tick(); c++; end
        repeat (20) tick();
        n_cmp++;
        want = {exp_tag, model_prod(exp_q[0])};
        if ({res_valid, res_tag, res_data} !== {1'b1, want}) begin
            n_bad++; $display("FAIL fill_held_result: got v=%b %h want v=1 %h", res_valid, {res_tag, res_data}, want);
        end
        n_cmp++;
        if ({mul_enable, fifo_level} !== {1'b0, 3'd4}) begin
            n_bad++; $display("FAIL fill_blocked: got en=%b lvl=%0d want en=0 lvl=4", mul_enable, fifo_level);
        end
        ready_force = 1'b1;
        wait_results(5, 400, ok);
        while (exp_q.size() > 0) begin
            pr = exp_q.pop_front();
            want = {exp_tag, model_prod(pr)};
            exp_tag++;
            have = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_cmp++;
            if (have !== want) begin n_bad++; $display("FAIL fill_result: got %h want %h", have, want); end
        end
    endtask

    task automatic test_sequence();
        bit acc, ok;
        logic [TW+PW-1:0] have, want;
        int unsigned g0, h0;
        logic [PW-1:0] consts [3];
        consts[0] = PW'(14); consts[1] = PW'(16); consts[2] = PW'(9);
        do_reset();
        g0 = gap_viol;
        h0 = hold_viol;
        mul_lat = 2;
        push_pair(W'(2), W'(7), 200, 1'b1, acc);
        push_pair(W'(4), W'(4), 200, 1'b1, acc);
        push_pair(W'(9), W'(1), 200, 1'b1, acc);
        wait_results(3, 200, ok);
        for (int i = 0; i < 3; i++) begin
            void'(exp_q.pop_front());
            want = {TW'(i), consts[i]};
            exp_tag++;
            have = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_cmp++;
            if (have !== want) begin n_bad++; $display("FAIL seq_result%0d: got %h want %h", i, have, want); end
        end
        n_cmp++;
        if (gap_viol != g0 || hold_viol != h0) begin
            n_bad++; $display("FAIL seq_protocol: got gap_viol=%0d hold_viol=%0d want 0", gap_viol - g0, hold_viol - h0);
        end
    endtask

    task automatic test_tag_wrap();
        bit acc, ok;
        logic [TW+PW-1:0] have, want;
        logic [2*W-1:0] pr;
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            mul_lat = $urandom_range(1, 4);
            push_pair({$urandom, $urandom}, {$urandom, $urandom}, 500, 1'b1, acc);
        end
        wait_results(17, 2000, ok);
        for (int i = 0; i < 17; i++) begin
            pr = exp_q.pop_front();
            want = {exp_tag, model_prod(pr)};
            exp_tag++;
            have = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_cmp++;
            if (have !== want) begin n_bad++; $display("FAIL wrap_result%0d: got %h want %h", i, have, want); end
            if (i == 16) begin
                n_cmp++;
                if (have[TW+PW-1:PW] !== TW'(0)) begin
                    n_bad++; $display("FAIL wrap_tag17: got %0d want 0", have[TW+PW-1:PW]);
                end
            end
        end
        rand_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit acc, ok;
        logic [TW+PW-1:0] have, want;
        logic [2*W-1:0] pr;
        int unsigned g0, h0;
        g0 = gap_viol;
        h0 = hold_viol;
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            mul_lat = $urandom_range(1, 8);
            push_pair({$urandom, $urandom}, {$urandom, $urandom}, 500, 1'b1, acc);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_results(40, 4000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL b2b_count: got %0d results want 40", got_q.size()); end
        while (exp_q.size() > 0) begin
            pr = exp_q.pop_front();
            want = {exp_tag, model_prod(pr)};
            exp_tag++;
            have = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_cmp++;
            if (have !== want) begin n_bad++; $display("FAIL b2b_result: got %h want %h", have, want); end
        end
        n_cmp++;
        if (gap_viol != g0 || hold_viol != h0) begin
            n_bad++; $display("FAIL b2b_protocol: got gap_viol=%0d hold_viol=%0d want 0", gap_viol - g0, hold_viol - h0);
        end
        rand_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        bit acc, ok;
        logic [TW+PW-1:0] have;
        int unsigned c;
        do_reset();
        mul_lat = 50;
        for (int i = 0; i < 3; i++) push_pair({$urandom, $urandom}, {$urandom, $urandom}, 200, 1'b1, acc);
        c = 0;
        while (mul_enable !== 1'b1 && c < 20) begin tick(); c++; end
        n_cmp++;
        if ({mul_enable, fifo_level} !== {1'b1, 3'd2}) begin
            n_bad++; $display("FAIL midop_setup: got en=%b lvl=%0d want en=1 lvl=2", mul_enable, fifo_level);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mul_enable, fifo_level, res_valid, in_ready} !== '0) begin
            n_bad++; $display("FAIL midop_async: got en=%b lvl=%0d v=%b rdy=%b want all 0",
                              mul_enable, fifo_level, res_valid, in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        tick();
        exp_q.delete();
        got_q.delete();
        exp_tag = '0;
        repeat (60) tick();
        n_cmp++;
        if (got_q.size() != 0 || mul_enable !== 1'b0) begin
            n_bad++; $display("FAIL midop_no_result: got %0d results en=%b want 0 results en=0", got_q.size(), mul_enable);
        end
        mul_lat = 4;
        push_pair(W'(6), W'(7), 200, 1'b1, acc);
        wait_results(1, 100, ok);
        have = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_cmp++;
        if (have !== {TW'(0), PW'(42)}) begin n_bad++; $display("FAIL midop_recover: got %h want tag 0 data 42", have); end
        void'(exp_q.pop_front());
        exp_tag++;
    endtask

`ifdef MUL_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit acc, ok;
        logic [TW+PW-1:0] have, want;
        logic [2*W-1:0] pr;
        int unsigned en_cycles, c;
        do_reset();
        stall = 1'b1;
        mul_lat = 2;
        push_pair({$urandom, $urandom}, {$urandom, $urandom}, 200, 1'b1, acc);
        push_pair({$urandom, $urandom}, {$urandom, $urandom}, 200, 1'b1, acc);
        en_cycles = 0;
        c = 0;
        while (c < 100) begin
            @(negedge clk);
            if (err === 1'b1) break;
            if (mul_enable === 1'b1) en_cycles++;
            c++;
        end
        n_cmp++;
        if (err !== 1'b1 || en_cycles != TO - 1) begin
            n_bad++; $display("FAIL tmo_err: got err=%b after %0d enable cycles want err=1 after %0d", err, en_cycles, TO - 1);
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL tmo_no_result: got %0d results want 0", got_q.size()); end
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        stall = 1'b0;
        wait_results(1, 100, ok);
        pr = exp_q.pop_front();
        want = {exp_tag, model_prod(pr)};
        exp_tag++;
        have = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_cmp++;
        if (have !== want) begin n_bad++; $display("FAIL tmo_next_pair: got %h want %h", have, want); end
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", err); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish want completion");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_tag = '0;
        test_reset();
        test_basic();
        test_fill();
        test_sequence();
        test_tag_wrap();
        test_back_to_back();
        test_reset_midop();
`ifdef MUL_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
